// File: rtl/m72_pkg.sv
// rtl/m72_pkg.sv - shared types for the m72 interrupt acknowledge responder
package m72_pkg;

  typedef enum logic [2:0] {
    IA_IDLE    = 3'd0,
    IA_ACK     = 3'd1,
    IA_RD_IP   = 3'd2,
    IA_RD_CS   = 3'd3,
    IA_DELIVER = 3'd4
  } int_ack_state_t;

  localparam int IVT_ENTRY_BYTES = 4;

  // Vector table entry address; the 9-bit byte offset is zero-extended into 20 bits.
  function automatic logic [19:0] ivt_addr(input logic [19:0] base, input logic [8:0] offset);
    return base + {11'd0, offset};
  endfunction

endpackage

// File: rtl/m72_int_ack_if.sv
// rtl/m72_int_ack_if.sv - controller handshake, IVT memory port and vector delivery bundle
interface m72_int_ack_if;
  logic        int_req;
  logic [8:0]  int_vector;
  logic        int_ack;
  logic        busy;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_din;
  logic        vec_valid;
  logic [15:0] vec_ip;
  logic [15:0] vec_cs;
  logic        vec_nmi;
  logic        vec_accept;

  modport master (
    input  int_req, int_vector, mem_ack, mem_din, vec_accept,
    output int_ack, busy, mem_req, mem_addr, vec_valid, vec_ip, vec_cs, vec_nmi
  );

  modport slave (
    output int_req, int_vector, mem_ack, mem_din, vec_accept,
    input  int_ack, busy, mem_req, mem_addr, vec_valid, vec_ip, vec_cs, vec_nmi
  );
endinterface

// File: rtl/m72_int_ack.sv
// rtl/m72_int_ack.sv - accepts INTR/NMI at instruction boundaries, acks the PIC and fetches CS:IP from the IVT
module m72_int_ack
  import m72_pkg::*;
#(
  parameter logic [19:0] IVT_BASE   = 20'h00000,
  parameter int          NMI_VECTOR = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic nmi,
  input  logic if_flag,
  input  logic boundary,
  m72_int_ack_if.master bus
);

  localparam logic [2:0] S_IDLE    = IA_IDLE;
  localparam logic [2:0] S_ACK     = IA_ACK;
  localparam logic [2:0] S_RD_IP   = IA_RD_IP;
  localparam logic [2:0] S_RD_CS   = IA_RD_CS;
  localparam logic [2:0] S_DELIVER = IA_DELIVER;

  localparam logic [8:0] NMI_OFFSET = 9'(NMI_VECTOR * IVT_ENTRY_BYTES);

  logic [2:0]  state_q, state_d;
  logic        int_ack_q, int_ack_d;
  logic        mem_req_q, mem_req_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic        vec_valid_q, vec_valid_d;
  logic        vec_nmi_q, vec_nmi_d;
  logic [15:0] vec_ip_q, vec_ip_d;
  logic [15:0] vec_cs_q, vec_cs_d;
  logic [8:0]  offset_q, offset_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic        nmi_prev_q, nmi_prev_d;

  logic nmi_edge;
  logic nmi_hit;
  logic word_done;

  // An edge arriving in the very cycle IDLE decides still wins over int_req.
  assign nmi_edge  = nmi & ~nmi_prev_q;
  assign nmi_hit   = nmi_pending_q | nmi_edge;
  assign word_done = mem_req_q & bus.mem_ack;

  always_comb begin
    state_d       = state_q;
    int_ack_d     = int_ack_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    vec_valid_d   = vec_valid_q;
    vec_nmi_d     = vec_nmi_q;
    vec_ip_d      = vec_ip_q;
    vec_cs_d      = vec_cs_q;
    offset_d      = offset_q;
    nmi_pending_d = nmi_pending_q;
    nmi_prev_d    = nmi_prev_q;

    if (ce) begin
      nmi_prev_d = nmi;
      if (nmi_edge) begin
        nmi_pending_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (boundary) begin
            if (nmi_hit) begin
              nmi_pending_d = 1'b0;
              vec_nmi_d     = 1'b1;
              mem_req_d     = 1'b1;
              mem_addr_d    = ivt_addr(IVT_BASE, NMI_OFFSET);
              state_d       = S_RD_IP;
            end else if (bus.int_req && if_flag) begin
              offset_d  = bus.int_vector;
              vec_nmi_d = 1'b0;
              int_ack_d = 1'b1;
              state_d   = S_ACK;
            end
          end
        end

        S_ACK: begin
          int_ack_d  = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = ivt_addr(IVT_BASE, offset_q);
          state_d    = S_RD_IP;
        end

        S_RD_IP: begin
          if (word_done) begin
            vec_ip_d   = bus.mem_din;
            mem_addr_d = mem_addr_q + 20'd2;
            state_d    = S_RD_CS;
          end
        end

        S_RD_CS: begin
          if (word_done) begin
            vec_cs_d    = bus.mem_din;
            mem_req_d   = 1'b0;
            vec_valid_d = 1'b1;
            state_d     = S_DELIVER;
          end
        end

        S_DELIVER: begin
          if (bus.vec_accept) begin
            vec_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end

        default: begin
          state_d     = S_IDLE;
          int_ack_d   = 1'b0;
          mem_req_d   = 1'b0;
          vec_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      int_ack_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 20'd0;
      vec_valid_q   <= 1'b0;
      vec_nmi_q     <= 1'b0;
      vec_ip_q      <= 16'd0;
      vec_cs_q      <= 16'd0;
      offset_q      <= 9'd0;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_ack_q     <= int_ack_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      vec_valid_q   <= vec_valid_d;
      vec_nmi_q     <= vec_nmi_d;
      vec_ip_q      <= vec_ip_d;
      vec_cs_q      <= vec_cs_d;
      offset_q      <= offset_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_prev_d;
    end
  end

  assign bus.int_ack   = int_ack_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_ip    = vec_ip_q;
  assign bus.vec_cs    = vec_cs_q;
  assign bus.vec_nmi   = vec_nmi_q;

endmodule

// File: tb/tb_m72_int_ack.sv
// tb/tb_m72_int_ack.sv - scoreboard bench for m72_int_ack with a wait-state IVT memory model
module tb_m72_int_ack;

  typedef struct packed {
    logic [15:0] ip;
    logic [15:0] cs;
    logic        nmi;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ce = 1'b1;
  logic nmi;
  logic if_flag;
  logic boundary;

  m72_int_ack_if bus();

  m72_int_ack #(.IVT_BASE(20'h00000), .NMI_VECTOR(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .nmi      (nmi),
    .if_flag  (if_flag),
    .boundary (boundary),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  vec_t        exp_vec_q[$];
  logic [19:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  bit ce_toggle = 1'b0;
  int acks_seen = 0;
  int acks_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    case (a)
      20'h00080: return 16'h1234;
      20'h00082: return 16'hF000;
      20'h00008: return 16'hABCD;
      20'h0000A: return 16'h5000;
      20'h00040: return 16'h1111;
      20'h00042: return 16'h2222;
      default:   return a[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  // Memory responder and clock-enable generator; also checks the address of every completed word.
  bit          trk_valid = 1'b0;
  logic [19:0] trk_addr = '0;
  int          cnt = 0;
  logic        req_prev = 1'b0;
  logic [19:0] addr_prev = '0;

  always @(negedge clk) begin
    if (bus.mem_ack && ce && req_prev) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_addr_unexpected actual=%h required=none", addr_prev);
      end else begin
        chk("mem_addr", 32'(addr_prev), 32'(exp_addr_q.pop_front()));
      end
    end else if (req_prev && bus.mem_req) begin
      chk("mem_addr_stable", 32'(bus.mem_addr), 32'(addr_prev));
    end

    if (!bus.mem_req) begin
      trk_valid = 1'b0;
    end else if (!trk_valid || bus.mem_addr != trk_addr) begin
      trk_valid = 1'b1;
      trk_addr  = bus.mem_addr;
      cnt       = 0;
    end else if (ce) begin
      cnt++;
    end

    ce          = ce_toggle ? ~ce : 1'b1;
    bus.mem_ack = bus.mem_req && trk_valid && (cnt >= wait_n);
    bus.mem_din = bus.mem_ack ? mem_word(bus.mem_addr) : 16'hDEAD;
    req_prev    = bus.mem_req;
    addr_prev   = bus.mem_addr;
  end

  // Delivery monitor: pops the scoreboard on each new vector and checks it stays frozen while held.
  logic vv_prev = 1'b0;
  logic ack_prev = 1'b0;
  vec_t vprev = '0;

  always @(negedge clk) begin
    if (bus.vec_valid && vv_prev) begin
      chk("vec_ip_stable", 32'(bus.vec_ip), 32'(vprev.ip));
      chk("vec_cs_stable", 32'(bus.vec_cs), 32'(vprev.cs));
      chk("vec_nmi_stable", 32'(bus.vec_nmi), 32'(vprev.nmi));
    end else if (bus.vec_valid) begin
      if (exp_vec_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL vec_unexpected actual=%h:%h required=none", bus.vec_cs, bus.vec_ip);
      end else begin
        vec_t e;
        e = exp_vec_q.pop_front();
        chk("vec_ip", 32'(bus.vec_ip), 32'(e.ip));
        chk("vec_cs", 32'(bus.vec_cs), 32'(e.cs));
        chk("vec_nmi", 32'(bus.vec_nmi), 32'(e.nmi));
      end
    end
    if (bus.int_ack && !ack_prev) acks_seen++;
    vv_prev  = bus.vec_valid;
    ack_prev = bus.int_ack;
    vprev    = {bus.vec_ip, bus.vec_cs, bus.vec_nmi};
  end

  // The controller withdraws int_req once it has seen the acknowledge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.int_ack) bus.int_req = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!bus.vec_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!bus.vec_valid) chk({name, "_timeout"}, 32'(bus.vec_valid), 32'd1);
  endtask

  task automatic accept();
    int n;
    n = 0;
    bus.vec_accept = 1'b1;
    while (bus.vec_valid && n < 100) begin
      tick();
      n++;
    end
    if (bus.vec_valid) chk("accept_timeout", 32'(bus.vec_valid), 32'd0);
    bus.vec_accept = 1'b0;
  endtask

  task automatic expect_seq(input logic [19:0] a, input logic [15:0] ip, input logic [15:0] cs, input logic n);
    exp_addr_q.push_back(a);
    exp_addr_q.push_back(a + 20'd2);
    exp_vec_q.push_back({ip, cs, n});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_int_ack"}, 32'(bus.int_ack), 32'd0);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_vec_valid"}, 32'(bus.vec_valid), 32'd0);
    chk({tag, "_vec_ip"}, 32'(bus.vec_ip), 32'd0);
    chk({tag, "_vec_cs"}, 32'(bus.vec_cs), 32'd0);
    chk({tag, "_vec_nmi"}, 32'(bus.vec_nmi), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  acks_before;
    bit  seen;

    reset          = 1'b1;
    nmi            = 1'b0;
    if_flag        = 1'b0;
    boundary       = 1'b0;
    bus.int_req    = 1'b0;
    bus.int_vector = 9'h000;
    bus.vec_accept = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Plain INTR, zero-wait memory
    expect_seq(20'h00080, 16'h1234, 16'hF000, 1'b0);
    acks_exp++;
    if_flag        = 1'b1;
    boundary       = 1'b1;
    bus.int_vector = 9'h080;
    bus.int_req    = 1'b1;
    tick();
    chk("t1_ack_high", 32'(bus.int_ack), 32'd1);
    tick();
    chk("t1_ack_one_cycle", 32'(bus.int_ack), 32'd0);
    wait_valid("t1", cyc);
    chk("t1_latency", 32'(cyc + 2), 32'd4);
    accept();

    // Ignored without boundary, then masked by IF, then taken when IF rises
    boundary       = 1'b0;
    bus.int_vector = 9'h100;
    bus.int_req    = 1'b1;
    seen           = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= bus.busy | bus.int_ack;
    end
    boundary = 1'b1;
    if_flag  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= bus.busy | bus.int_ack;
    end
    chk("t2_masked_idle", 32'(seen), 32'd0);
    expect_seq(20'h00100, 16'hA4A5, 16'hA4A7, 1'b0);
    acks_exp++;
    if_flag = 1'b1;
    wait_valid("t2", cyc);
    chk("t2_latency", 32'(cyc), 32'd4);
    accept();

    // NMI edge together with int_req: NMI first, then the INTR
    expect_seq(20'h00008, 16'hABCD, 16'h5000, 1'b1);
    expect_seq(20'h00040, 16'h1111, 16'h2222, 1'b0);
    acks_exp++;
    acks_before    = acks_seen;
    bus.int_vector = 9'h040;
    bus.int_req    = 1'b1;
    nmi            = 1'b1;
    wait_valid("t3_nmi", cyc);
    chk("t3_nmi_latency", 32'(cyc), 32'd3);
    chk("t3_no_ack_for_nmi", 32'(acks_seen), 32'(acks_before));
    chk("t3_req_still_held", 32'(bus.int_req), 32'd1);
    nmi = 1'b0;
    accept();
    wait_valid("t3_intr", cyc);
    chk("t3_intr_latency", 32'(cyc), 32'd4);
    accept();

    // Wait states plus ce at half rate
    wait_n    = 3;
    ce_toggle = 1'b1;
    expect_seq(20'h00080, 16'h1234, 16'hF000, 1'b0);
    acks_exp++;
    bus.int_vector = 9'h080;
    bus.int_req    = 1'b1;
    wait_valid("t4", cyc);
    accept();
    wait_n    = 0;
    ce_toggle = 1'b0;
    repeat (2) tick();

    // Backpressure with an NMI edge arriving during DELIVER
    expect_seq(20'h00040, 16'h1111, 16'h2222, 1'b0);
    acks_exp++;
    bus.int_vector = 9'h040;
    bus.int_req    = 1'b1;
    wait_valid("t5", cyc);
    expect_seq(20'h00008, 16'hABCD, 16'h5000, 1'b1);
    repeat (3) tick();
    nmi = 1'b1;
    repeat (2) tick();
    nmi = 1'b0;
    repeat (5) tick();
    chk("t5_held_valid", 32'(bus.vec_valid), 32'd1);
    accept();
    wait_valid("t5_nmi", cyc);
    chk("t5_nmi_latency", 32'(cyc), 32'd3);
    accept();

    // Reset while in RD_CS, then a full fresh sequence
    wait_n = 6;
    exp_addr_q.push_back(20'h00080);
    acks_exp++;
    bus.int_vector = 9'h080;
    bus.int_req    = 1'b1;
    cyc = 0;
    while (bus.mem_addr != 20'h00082 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t6_reached_rd_cs", 32'(bus.mem_addr), 32'h00082);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_reset");
    tick();
    tick();
    reset  = 1'b0;
    wait_n = 0;
    expect_seq(20'h00080, 16'h1234, 16'hF000, 1'b0);
    acks_exp++;
    bus.int_req = 1'b1;
    wait_valid("t6", cyc);
    chk("t6_latency", 32'(cyc), 32'd4);
    accept();

    repeat (5) tick();
    chk("int_ack_count", 32'(acks_seen), 32'(acks_exp));
    chk("vec_scoreboard_empty", 32'(exp_vec_q.size()), 32'd0);
    chk("addr_scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
